// File: rtl/issue_pkg.sv
// issue_pkg: widths and types shared by the issue stage, its operand
// resolver and its bus interface. Nothing else in the slice redefines them.
package issue_pkg;

  localparam int INS_OP_W  = 7;
  localparam int REG_DAT_W = 32;
  localparam int ROB_ADD_W = 5;
  localparam int REG_IDX_W = 5;
  localparam int NUM_REGS  = 32;

  typedef logic [ROB_ADD_W-1:0] rob_tag_t;
  typedef logic [REG_DAT_W-1:0] reg_dat_t;
  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [INS_OP_W-1:0]  ins_op_t;

  // Registered issue payload. A source tag of 0 means the operand value is ready.
  typedef struct packed {
    ins_op_t  op;
    reg_dat_t pc;
    reg_dat_t imm;
    reg_dat_t vs1;
    reg_dat_t vs2;
    rob_tag_t qs1;
    rob_tag_t qs2;
    rob_tag_t qd;
  } is_payload_t;

  // A CDB broadcast satisfies a waiting operand. Tag 0 never waits.
  function automatic logic cdb_hit(input logic en, input rob_tag_t qd, input rob_tag_t tag);
    return en && (tag != '0) && (qd == tag);
  endfunction

endpackage

// File: rtl/issue_if.sv
// issue_if: every non-clock/reset signal of the issue stage.
//   slave  - the issue block (takes IQ/ROB/RF/CDB inputs, drives issue outputs)
//   master - the surrounding core / testbench
interface issue_if;
  import issue_pkg::*;

  logic     en;
  logic     iIQ_En;
  ins_op_t  iIQ_Op;
  reg_dat_t iIQ_Pc, iIQ_Imm;
  reg_idx_t iIQ_Rs1, iIQ_Rs2, iIQ_Rd;
  logic     iIQ_HasRd, iIQ_IsLs;
  logic     oIQ_Rdy;
  logic     iROB_Full;
  rob_tag_t iROB_Tail;
  logic     oROB_En;
  rob_tag_t oROB_Q1, oROB_Q2;
  logic     iROB_Rdy1, iROB_Rdy2;
  reg_dat_t iROB_V1, iROB_V2;
  reg_idx_t oRF_Rs1, oRF_Rs2;
  reg_dat_t iRF_V1, iRF_V2;
  logic     iRS_Full, iLSB_Full;
  logic     iEX_En, iLSB_En;
  rob_tag_t iEX_Qd, iLSB_Qd;
  reg_dat_t iEX_Vd, iLSB_Vd;
  logic     iCMT_En;
  reg_idx_t iCMT_Rd;
  rob_tag_t iCMT_Qd;
  logic     iFlush;
  logic     oRS_En, oLSB_En;
  ins_op_t  oIS_Op;
  reg_dat_t oIS_Pc, oIS_Imm, oIS_Vs1, oIS_Vs2;
  rob_tag_t oIS_Qs1, oIS_Qs2, oIS_Qd;

  modport slave (
    input  en, iIQ_En, iIQ_Op, iIQ_Pc, iIQ_Imm, iIQ_Rs1, iIQ_Rs2, iIQ_Rd,
           iIQ_HasRd, iIQ_IsLs, iROB_Full, iROB_Tail, iROB_Rdy1, iROB_Rdy2,
           iROB_V1, iROB_V2, iRF_V1, iRF_V2, iRS_Full, iLSB_Full,
           iEX_En, iEX_Qd, iEX_Vd, iLSB_En, iLSB_Qd, iLSB_Vd,
           iCMT_En, iCMT_Rd, iCMT_Qd, iFlush,
    output oIQ_Rdy, oROB_En, oROB_Q1, oROB_Q2, oRF_Rs1, oRF_Rs2,
           oRS_En, oLSB_En, oIS_Op, oIS_Pc, oIS_Imm, oIS_Vs1, oIS_Vs2,
           oIS_Qs1, oIS_Qs2, oIS_Qd
  );

  modport master (
    output en, iIQ_En, iIQ_Op, iIQ_Pc, iIQ_Imm, iIQ_Rs1, iIQ_Rs2, iIQ_Rd,
           iIQ_HasRd, iIQ_IsLs, iROB_Full, iROB_Tail, iROB_Rdy1, iROB_Rdy2,
           iROB_V1, iROB_V2, iRF_V1, iRF_V2, iRS_Full, iLSB_Full,
           iEX_En, iEX_Qd, iEX_Vd, iLSB_En, iLSB_Qd, iLSB_Vd,
           iCMT_En, iCMT_Rd, iCMT_Qd, iFlush,
    input  oIQ_Rdy, oROB_En, oROB_Q1, oROB_Q2, oRF_Rs1, oRF_Rs2,
           oRS_En, oLSB_En, oIS_Op, oIS_Pc, oIS_Imm, oIS_Vs1, oIS_Vs2,
           oIS_Qs1, oIS_Qs2, oIS_Qd
  );

endinterface

// File: rtl/issue_opd.sv
// issue_opd: resolves one source operand in the issue cycle.
//   idx      architectural source register
//   tag      current rename mapping of idx (0 = not renamed)
//   rf_v     regfile value of idx
//   ex_*     EX CDB broadcast, lsb_* LSB CDB broadcast
//   rob_*    ROB lookup result for tag
//   v, q     resolved value and waiting tag (q = 0 means v is valid)
module issue_opd
  import issue_pkg::*;
(
  input  reg_idx_t idx,
  input  rob_tag_t tag,
  input  reg_dat_t rf_v,
  input  logic     ex_en,
  input  rob_tag_t ex_qd,
  input  reg_dat_t ex_vd,
  input  logic     lsb_en,
  input  rob_tag_t lsb_qd,
  input  reg_dat_t lsb_vd,
  input  logic     rob_rdy,
  input  reg_dat_t rob_v,
  output reg_dat_t v,
  output rob_tag_t q
);

  always_comb begin
    v = '0;
    q = '0;
    if (idx == '0) begin
      v = '0;
    end else if (tag == '0) begin
      v = rf_v;
    end else if (cdb_hit(ex_en, ex_qd, tag)) begin
      v = ex_vd;
    end else if (cdb_hit(lsb_en, lsb_qd, tag)) begin
      v = lsb_vd;
    end else if (rob_rdy) begin
      v = rob_v;
    end else begin
      q = tag;
    end
  end

endmodule

// File: rtl/issue.sv
// issue: rename-and-issue stage. Takes one instruction-queue entry per cycle,
// allocates a ROB tag, resolves both sources (rename table, regfile, CDB,
// ROB) and sends a registered payload to the RS or the LSB one cycle later.
//   clk  clock, rising edge
//   rst  synchronous, active-high reset
//   bus  issue_if.slave: IQ entry, ROB alloc/lookup, regfile read, CDB,
//        commit, flush and the shared issue payload
module issue
  import issue_pkg::*;
(
  input logic      clk,
  input logic      rst,
  issue_if.slave   bus
);

  rob_tag_t    rename_q [NUM_REGS];
  rob_tag_t    rename_d [NUM_REGS];
  is_payload_t pay_q, pay_d;
  logic        rs_en_q, rs_en_d;
  logic        lsb_en_q, lsb_en_d;

  logic        tgt_full;
  logic        fire;
  rob_tag_t    tag1, tag2;
  reg_dat_t    vs1, vs2;
  rob_tag_t    qs1, qs2;

  assign tgt_full = bus.iIQ_IsLs ? bus.iLSB_Full : bus.iRS_Full;
  assign fire     = !rst && bus.en && bus.iIQ_En && !bus.iROB_Full && !bus.iFlush && !tgt_full;

  // Lookups use the table as it stands before this cycle's update, so an
  // instruction whose rd equals a source still reads the older producer.
  assign tag1 = rename_q[bus.iIQ_Rs1];
  assign tag2 = rename_q[bus.iIQ_Rs2];

  assign bus.oIQ_Rdy = fire;
  assign bus.oROB_En = fire;
  assign bus.oROB_Q1 = tag1;
  assign bus.oROB_Q2 = tag2;
  assign bus.oRF_Rs1 = bus.iIQ_Rs1;
  assign bus.oRF_Rs2 = bus.iIQ_Rs2;

  issue_opd u_opd1 (
    .idx(bus.iIQ_Rs1), .tag(tag1), .rf_v(bus.iRF_V1),
    .ex_en(bus.iEX_En), .ex_qd(bus.iEX_Qd), .ex_vd(bus.iEX_Vd),
    .lsb_en(bus.iLSB_En), .lsb_qd(bus.iLSB_Qd), .lsb_vd(bus.iLSB_Vd),
    .rob_rdy(bus.iROB_Rdy1), .rob_v(bus.iROB_V1), .v(vs1), .q(qs1)
  );

  issue_opd u_opd2 (
    .idx(bus.iIQ_Rs2), .tag(tag2), .rf_v(bus.iRF_V2),
    .ex_en(bus.iEX_En), .ex_qd(bus.iEX_Qd), .ex_vd(bus.iEX_Vd),
    .lsb_en(bus.iLSB_En), .lsb_qd(bus.iLSB_Qd), .lsb_vd(bus.iLSB_Vd),
    .rob_rdy(bus.iROB_Rdy2), .rob_v(bus.iROB_V2), .v(vs2), .q(qs2)
  );

  // Flush beats everything; otherwise a commit clears only a still-current
  // mapping, and a same-cycle rename of that register overwrites the clear.
  always_comb begin
    rename_d = rename_q;
    if (bus.en) begin
      if (bus.iFlush) begin
        for (int i = 0; i < NUM_REGS; i++) rename_d[i] = '0;
      end else begin
        if (bus.iCMT_En && (rename_q[bus.iCMT_Rd] == bus.iCMT_Qd))
          rename_d[bus.iCMT_Rd] = '0;
        if (fire && bus.iIQ_HasRd && (bus.iIQ_Rd != '0))
          rename_d[bus.iIQ_Rd] = bus.iROB_Tail;
      end
    end
    rename_d[0] = '0;
  end

  always_comb begin
    pay_d    = pay_q;
    rs_en_d  = rs_en_q;
    lsb_en_d = lsb_en_q;
    if (bus.en) begin
      rs_en_d  = fire && !bus.iIQ_IsLs;
      lsb_en_d = fire && bus.iIQ_IsLs;
      if (fire) begin
        pay_d.op  = bus.iIQ_Op;
        pay_d.pc  = bus.iIQ_Pc;
        pay_d.imm = bus.iIQ_Imm;
        pay_d.vs1 = vs1;
        pay_d.vs2 = vs2;
        pay_d.qs1 = qs1;
        pay_d.qs2 = qs2;
        pay_d.qd  = bus.iROB_Tail;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) rename_q[i] <= '0;
      pay_q    <= '0;
      rs_en_q  <= 1'b0;
      lsb_en_q <= 1'b0;
    end else begin
      rename_q <= rename_d;
      pay_q    <= pay_d;
      rs_en_q  <= rs_en_d;
      lsb_en_q <= lsb_en_d;
    end
  end

  // A result broadcast while the payload is on the bus would otherwise be
  // missed by the receiver, so it is folded in here (EX before LSB).
  always_comb begin
    bus.oIS_Qs1 = pay_q.qs1;
    bus.oIS_Vs1 = pay_q.vs1;
    if (cdb_hit(bus.iEX_En, bus.iEX_Qd, pay_q.qs1)) begin
      bus.oIS_Qs1 = '0;
      bus.oIS_Vs1 = bus.iEX_Vd;
    end else if (cdb_hit(bus.iLSB_En, bus.iLSB_Qd, pay_q.qs1)) begin
      bus.oIS_Qs1 = '0;
      bus.oIS_Vs1 = bus.iLSB_Vd;
    end
  end

  always_comb begin
    bus.oIS_Qs2 = pay_q.qs2;
    bus.oIS_Vs2 = pay_q.vs2;
    if (cdb_hit(bus.iEX_En, bus.iEX_Qd, pay_q.qs2)) begin
      bus.oIS_Qs2 = '0;
      bus.oIS_Vs2 = bus.iEX_Vd;
    end else if (cdb_hit(bus.iLSB_En, bus.iLSB_Qd, pay_q.qs2)) begin
      bus.oIS_Qs2 = '0;
      bus.oIS_Vs2 = bus.iLSB_Vd;
    end
  end

  assign bus.oRS_En  = rs_en_q;
  assign bus.oLSB_En = lsb_en_q;
  assign bus.oIS_Op  = pay_q.op;
  assign bus.oIS_Pc  = pay_q.pc;
  assign bus.oIS_Imm = pay_q.imm;
  assign bus.oIS_Qd  = pay_q.qd;

endmodule

// File: tb/tb_issue.sv
module tb_issue;

  typedef struct {
    bit        rst, en, iq_en, has_rd, is_ls, rob_full;
    bit [6:0]  op;
    bit [31:0] pc, imm;
    bit [4:0]  rs1, rs2, rd, tail;
    bit        rob_rdy1, rob_rdy2;
    bit [31:0] rob_v1, rob_v2, rf_v1, rf_v2;
    bit        rs_full, lsb_full;
    bit        ex_en, lsb_en;
    bit [4:0]  ex_qd, lsb_qd;
    bit [31:0] ex_vd, lsb_vd;
    bit        cmt_en;
    bit [4:0]  cmt_rd, cmt_qd;
    bit        flush;
  } stim_t;

  typedef struct {
    bit        chk;
    bit        rs_en, lsb_en;
    bit [6:0]  op;
    bit [31:0] pc, imm, vs1, vs2;
    bit [4:0]  qs1, qs2, qd;
  } out_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  issue_if bus ();
  issue u_dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int checks   = 0;
  int failures = 0;

  // reference state: architectural rename map and the visible output state
  bit [4:0] ren [32];
  out_t     out_m;
  out_t     exp_q [$];
  stim_t    cur;
  bit       started  = 1'b0;
  bit       chk_comb = 1'b0;
  bit       exp_fire = 1'b0;
  bit [4:0] exp_rq1, exp_rq2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    s.en   = 1'b1;
    s.tail = 5'd1;
    return s;
  endfunction

  // Operand value/tag from the documented priority order.
  function automatic void resolve(input bit [4:0] idx, input bit [31:0] rf, input bit rr,
                                  input bit [31:0] rv, input stim_t s,
                                  output bit [31:0] v, output bit [4:0] q);
    bit [4:0] t;
    t = ren[idx];
    v = 0; q = 0;
    if (idx == 0) v = 0;
    else if (t == 0) v = rf;
    else if (s.ex_en && s.ex_qd == t) v = s.ex_vd;
    else if (s.lsb_en && s.lsb_qd == t) v = s.lsb_vd;
    else if (rr) v = rv;
    else q = t;
  endfunction

  task automatic step(input stim_t s);
    bit fire, tfull;
    bit [31:0] v1, v2;
    bit [4:0]  q1, q2;
    @(posedge clk);
    #2;
    cur = s;
    rst = s.rst;
    bus.en = s.en;            bus.iIQ_En = s.iq_en;     bus.iIQ_Op = s.op;
    bus.iIQ_Pc = s.pc;        bus.iIQ_Imm = s.imm;      bus.iIQ_Rs1 = s.rs1;
    bus.iIQ_Rs2 = s.rs2;      bus.iIQ_Rd = s.rd;        bus.iIQ_HasRd = s.has_rd;
    bus.iIQ_IsLs = s.is_ls;   bus.iROB_Full = s.rob_full; bus.iROB_Tail = s.tail;
    bus.iROB_Rdy1 = s.rob_rdy1; bus.iROB_Rdy2 = s.rob_rdy2;
    bus.iROB_V1 = s.rob_v1;   bus.iROB_V2 = s.rob_v2;
    bus.iRF_V1 = s.rf_v1;     bus.iRF_V2 = s.rf_v2;
    bus.iRS_Full = s.rs_full; bus.iLSB_Full = s.lsb_full;
    bus.iEX_En = s.ex_en;     bus.iEX_Qd = s.ex_qd;     bus.iEX_Vd = s.ex_vd;
    bus.iLSB_En = s.lsb_en;   bus.iLSB_Qd = s.lsb_qd;   bus.iLSB_Vd = s.lsb_vd;
    bus.iCMT_En = s.cmt_en;   bus.iCMT_Rd = s.cmt_rd;   bus.iCMT_Qd = s.cmt_qd;
    bus.iFlush = s.flush;
    started = 1'b1;
    if (s.rst) begin
      exp_fire = 1'b0;
      chk_comb = 1'b0;
      for (int r = 0; r < 32; r++) ren[r] = 0;
      out_m = '{default: '0};
      out_m.chk = 1'b1;
      exp_q.push_back(out_m);
    end else begin
      tfull = s.is_ls ? s.lsb_full : s.rs_full;
      fire  = s.en && s.iq_en && !s.rob_full && !s.flush && !tfull;
      exp_fire = fire;
      exp_rq1  = ren[s.rs1];
      exp_rq2  = ren[s.rs2];
      chk_comb = 1'b1;
      resolve(s.rs1, s.rf_v1, s.rob_rdy1, s.rob_v1, s, v1, q1);
      resolve(s.rs2, s.rf_v2, s.rob_rdy2, s.rob_v2, s, v2, q2);
      if (s.en) begin
        if (s.flush) begin
          for (int r = 0; r < 32; r++) ren[r] = 0;
          out_m.rs_en  = 1'b0;
          out_m.lsb_en = 1'b0;
        end else begin
          if (s.cmt_en && ren[s.cmt_rd] == s.cmt_qd) ren[s.cmt_rd] = 0;
          if (fire && s.has_rd && s.rd != 0) ren[s.rd] = s.tail;
          out_m.rs_en  = fire && !s.is_ls;
          out_m.lsb_en = fire && s.is_ls;
          if (fire) begin
            out_m.op = s.op;   out_m.pc = s.pc;   out_m.imm = s.imm;
            out_m.vs1 = v1;    out_m.vs2 = v2;
            out_m.qs1 = q1;    out_m.qs2 = q2;    out_m.qd = s.tail;
          end
        end
      end
      ren[0] = 0;
      out_m.chk = out_m.rs_en || out_m.lsb_en;
      exp_q.push_back(out_m);
    end
  endtask

  // Monitor: mid-cycle, compares combinational outputs against this cycle's
  // expectations and the registered outputs against the record queued one
  // cycle earlier, with any CDB broadcast of this cycle folded in.
  always @(negedge clk) begin
    out_t r;
    bit [31:0] ev1, ev2;
    bit [4:0]  eq1, eq2;
    if (started) begin
      chk("iq_rdy", 32'(bus.oIQ_Rdy), 32'(exp_fire));
      chk("rob_en", 32'(bus.oROB_En), 32'(exp_fire));
      if (chk_comb) begin
        chk("rob_q1", 32'(bus.oROB_Q1), 32'(exp_rq1));
        chk("rob_q2", 32'(bus.oROB_Q2), 32'(exp_rq2));
        chk("rf_rs1", 32'(bus.oRF_Rs1), 32'(cur.rs1));
        chk("rf_rs2", 32'(bus.oRF_Rs2), 32'(cur.rs2));
      end
      if (exp_q.size() > 1) begin
        r = exp_q.pop_front();
        chk("rs_en",  32'(bus.oRS_En),  32'(r.rs_en));
        chk("lsb_en", 32'(bus.oLSB_En), 32'(r.lsb_en));
        if (r.chk) begin
          ev1 = r.vs1; eq1 = r.qs1; ev2 = r.vs2; eq2 = r.qs2;
          if (eq1 != 0 && cur.ex_en && cur.ex_qd == eq1) begin ev1 = cur.ex_vd; eq1 = 0; end
          else if (eq1 != 0 && cur.lsb_en && cur.lsb_qd == eq1) begin ev1 = cur.lsb_vd; eq1 = 0; end
          if (eq2 != 0 && cur.ex_en && cur.ex_qd == eq2) begin ev2 = cur.ex_vd; eq2 = 0; end
          else if (eq2 != 0 && cur.lsb_en && cur.lsb_qd == eq2) begin ev2 = cur.lsb_vd; eq2 = 0; end
          chk("is_op",  32'(bus.oIS_Op),  32'(r.op));
          chk("is_pc",  bus.oIS_Pc,       r.pc);
          chk("is_imm", bus.oIS_Imm,      r.imm);
          chk("is_vs1", bus.oIS_Vs1,      ev1);
          chk("is_vs2", bus.oIS_Vs2,      ev2);
          chk("is_qs1", 32'(bus.oIS_Qs1), 32'(eq1));
          chk("is_qs2", 32'(bus.oIS_Qs2), 32'(eq2));
          chk("is_qd",  32'(bus.oIS_Qd),  32'(r.qd));
        end
      end
    end
  end

  function automatic stim_t rand_stim();
    stim_t s;
    s = idle();
    s.en       = ($urandom_range(0, 15) != 0);
    s.iq_en    = ($urandom_range(0, 3) != 0);
    s.op       = 7'($urandom);
    s.pc       = $urandom;
    s.imm      = $urandom;
    s.rs1      = 5'($urandom_range(0, 7));
    s.rs2      = 5'($urandom_range(0, 7));
    s.rd       = 5'($urandom_range(0, 7));
    s.has_rd   = ($urandom_range(0, 3) != 0);
    s.is_ls    = ($urandom_range(0, 2) == 0);
    s.rob_full = ($urandom_range(0, 9) == 0);
    s.tail     = 5'($urandom_range(1, 7));
    s.rob_rdy1 = ($urandom_range(0, 3) == 0);
    s.rob_rdy2 = ($urandom_range(0, 3) == 0);
    s.rob_v1   = $urandom;
    s.rob_v2   = $urandom;
    s.rf_v1    = $urandom;
    s.rf_v2    = $urandom;
    s.rs_full  = ($urandom_range(0, 5) == 0);
    s.lsb_full = ($urandom_range(0, 5) == 0);
    s.ex_en    = ($urandom_range(0, 2) == 0);
    s.ex_qd    = 5'($urandom_range(1, 7));
    s.ex_vd    = $urandom;
    s.lsb_en   = ($urandom_range(0, 2) == 0);
    s.lsb_qd   = 5'($urandom_range(1, 7));
    s.lsb_vd   = $urandom;
    s.cmt_en   = ($urandom_range(0, 2) == 0);
    s.cmt_rd   = 5'($urandom_range(0, 7));
    s.cmt_qd   = 5'($urandom_range(1, 7));
    s.flush    = ($urandom_range(0, 40) == 0);
    s.rst      = ($urandom_range(0, 300) == 0);
    return s;
  endfunction

  initial begin
    stim_t s;
    bus.en = 1'b0; bus.iIQ_En = 1'b0; bus.iIQ_Op = '0; bus.iIQ_Pc = '0; bus.iIQ_Imm = '0;
    bus.iIQ_Rs1 = '0; bus.iIQ_Rs2 = '0; bus.iIQ_Rd = '0; bus.iIQ_HasRd = 1'b0; bus.iIQ_IsLs = 1'b0;
    bus.iROB_Full = 1'b0; bus.iROB_Tail = 5'd1; bus.iROB_Rdy1 = 1'b0; bus.iROB_Rdy2 = 1'b0;
    bus.iROB_V1 = '0; bus.iROB_V2 = '0; bus.iRF_V1 = '0; bus.iRF_V2 = '0;
    bus.iRS_Full = 1'b0; bus.iLSB_Full = 1'b0; bus.iEX_En = 1'b0; bus.iEX_Qd = '0; bus.iEX_Vd = '0;
    bus.iLSB_En = 1'b0; bus.iLSB_Qd = '0; bus.iLSB_Vd = '0; bus.iCMT_En = 1'b0; bus.iCMT_Rd = '0;
    bus.iCMT_Qd = '0; bus.iFlush = 1'b0;

    s = idle(); s.rst = 1'b1;
    repeat (3) step(s);
    s = idle(); step(s);

    // ADD x3,x1,x2 from a clean map, tail 4
    s = idle(); s.iq_en = 1; s.op = 7'h33; s.rs1 = 1; s.rs2 = 2; s.rd = 3; s.has_rd = 1;
    s.tail = 4; s.rf_v1 = 5; s.rf_v2 = 7; s.pc = 32'h100;
    step(s);
    // consumer of x3 while tag 4 is not ready
    s = idle(); s.iq_en = 1; s.rs1 = 3; s.rd = 5; s.has_rd = 1; s.tail = 5; s.pc = 32'h104;
    step(s);
    s = idle(); step(s);
    // consumer of x3 while EX broadcasts tag 4
    s = idle(); s.iq_en = 1; s.rs1 = 3; s.rd = 6; s.has_rd = 1; s.tail = 2;
    s.ex_en = 1; s.ex_qd = 4; s.ex_vd = 9;
    step(s);
    // x7 <- tag 6, then consumer of x7 on rs2, LSB broadcast of tag 6 in its output cycle
    s = idle(); s.iq_en = 1; s.rd = 7; s.has_rd = 1; s.tail = 6; step(s);
    s = idle(); s.iq_en = 1; s.rs2 = 7; s.tail = 3; step(s);
    s = idle(); s.lsb_en = 1; s.lsb_qd = 6; s.lsb_vd = 32'h55; step(s);
    // RS full blocks an ALU op; a load goes through to the LSB
    s = idle(); s.iq_en = 1; s.rs_full = 1; s.rd = 9; s.has_rd = 1; s.tail = 7; step(s);
    s = idle(); s.iq_en = 1; s.rs_full = 1; s.is_ls = 1; s.rs1 = 1; s.rd = 10; s.has_rd = 1; s.tail = 8; step(s);
    // remap x3 to 7, stale commit of tag 4 must not clear it
    s = idle(); s.iq_en = 1; s.rd = 3; s.has_rd = 1; s.tail = 7; step(s);
    s = idle(); s.cmt_en = 1; s.cmt_rd = 3; s.cmt_qd = 4; s.rs1 = 3; step(s);
    s = idle(); s.rs1 = 3; step(s);
    // pending output then flush
    s = idle(); s.iq_en = 1; s.rs1 = 3; s.rd = 11; s.has_rd = 1; s.tail = 9; step(s);
    s = idle(); s.flush = 1; s.iq_en = 1; s.rs1 = 3; step(s);
    s = idle(); s.rs1 = 3; s.rs2 = 10; step(s);
    // disabled cycle holds state
    s = idle(); s.iq_en = 1; s.rd = 4; s.has_rd = 1; s.tail = 12; step(s);
    s = idle(); s.en = 0; s.iq_en = 1; s.flush = 1; s.rs1 = 4; step(s);
    s = idle(); s.rs1 = 4; step(s);

    for (int i = 0; i < 3000; i++) step(rand_stim());

    s = idle(); step(s);
    step(s);
    @(posedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
